// File: rtl/proc_pkg.sv
// Shared definitions for the processor issue sequencer and the processor bench.
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    WAIT_CLR  = 3'd3,
    FINISH    = 3'd4,
    ERROR     = 3'd5
  } seq_state_t;

  localparam int ADDR_W_DEF = 5;

  // Opcodes understood by projetoProcessador.
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_BR  = 3'b111;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; stops at zero. Shared between run-hold and timeout counts.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/proc_sequencer.sv
// Walks FIRST_ADDR..LAST_ADDR, issuing each address to the processor with a
// run pulse and waiting for done to rise and fall, with timeout detection.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31,
  parameter int RUN_HOLD   = 2,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              done,
  output logic [ADDR_W-1:0] Din,
  output logic              run,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  issued
);

  localparam int TMAX = (RUN_HOLD > TIMEOUT) ? RUN_HOLD : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]     HOLD_LD = TW'(RUN_HOLD - 1);
  localparam logic [TW-1:0]     TOUT_LD = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] din_q, din_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              stop_req_q, stop_req_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              terr_q, terr_d;
  logic              restart;
  logic              tmr_load, tmr_zero;
  logic [TW-1:0]     tmr_val;

  // The timer is reloaded on every state change; the value depends on the
  // state being entered, so one counter serves both run-hold and timeout.
  seq_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // FSM, address/issued/stop_req next state, timer control and output decode.
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    issued_d   = issued_q;
    stop_req_d = stop_req_q;
    restart    = 1'b0;

    case (state_q)
      IDLE, FINISH, ERROR: if (start) restart = 1'b1;
      ISSUE: if (tmr_zero) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done) begin
          state_d = WAIT_CLR;
          if (issued_q != '1) issued_d = issued_q + CNT_W'(1);
        end else if (tmr_zero) begin
          state_d = ERROR;
        end
      end
      WAIT_CLR: begin
        if (!done) begin
          if (stop_req_q || stop)  state_d = IDLE;
          else if (din_q == LAST_A) state_d = FINISH;
          else begin
            din_d   = din_q + ADDR_W'(1);
            state_d = ISSUE;
          end
        end else if (tmr_zero) begin
          state_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d    = ISSUE;
      din_d      = FIRST_A;
      issued_d   = '0;
      stop_req_d = stop;
    end else if (state_q == WAIT_CLR && state_d == IDLE) begin
      stop_req_d = 1'b0;
    end else if (busy_q) begin
      stop_req_d = stop_req_q | stop;
    end

    tmr_load = (state_d != state_q);
    if (state_d == ISSUE)                                tmr_val = HOLD_LD;
    else if (state_d == WAIT_DONE || state_d == WAIT_CLR) tmr_val = TOUT_LD;
    else                                                  tmr_val = '0;

    run_d      = (state_d == ISSUE);
    busy_d     = (state_d == ISSUE) || (state_d == WAIT_DONE) || (state_d == WAIT_CLR);
    finished_d = (state_d == FINISH);
    terr_d     = (state_d == ERROR);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      din_q      <= '0;
      issued_q   <= '0;
      stop_req_q <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      issued_q   <= issued_d;
      stop_req_q <= stop_req_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      terr_q     <= terr_d;
    end
  end

  assign Din         = din_q;
  assign run         = run_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timeout_err = terr_q;
  assign issued      = issued_q;

endmodule
